fft_r22sdf_tw_ctrl: RTL and testbench
=====================================

# fft_r22sdf_tw_ctrl

Twiddle scheduler for one R2²SDF FFT stage. It tracks the sample index of each frame, computes the twiddle exponent for that sample and drives the twiddle ROM address. It then delivers the clock enable and valid strobe that the stage's complex twiddle multiplier needs, aligned with the ROM data. One instance sits between each butterfly pair (BF2I/BF2II) and the following twiddle multiplier. The last stage has no multiplier and no instance.

## Interface

- FFT_N, 1024: transform length.
- NLOG2, 10: log2(FFT_N); must be even.
- STAGE, 0: stage pair index, 0 .. NLOG2/2-2.
- clk_i  in  1  system clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- valid_i  in  1  sample present at the multiplier data input this cycle.
- start_i  in  1  marks the first sample of a frame; meaningful only with valid_i=1.
- ctr_o  out  NLOG2  index within the frame of the most recently accepted sample.
- rom_en_o  out  1  twiddle ROM read enable.
- rom_addr_o  out  NLOG2  twiddle ROM address (exponent e of W_N^e).
- ce_o  out  1  multiplier clock enable; aligned with ROM data.
- valid_o  out  1  multiplier output valid; equal to ce_o.
- trivial_o  out  1  the twiddle for the sample at ce_o is W^0 = 1; aligned with ce_o.
- frame_done_o  out  1  one-cycle pulse, aligned with ce_o of sample N-1.
- sync_err_o  out  1  one-cycle pulse when start_i arrives mid-frame.

## Operation

- FSM states:
  - IDLE: no frame in progress.
  - RUN: frame in progress; ctr holds the index of the last accepted sample.
- IDLE transitions:
  - valid_i && start_i → accept the sample as index 0 and go to RUN.
  - valid_i without start_i → sample ignored; no ROM read, no ce_o.
- RUN transitions:
  - valid_i && !start_i → ctr+1.
  - Sample N-1 accepted → go to IDLE.
  - valid_i=0 → hold; gaps of any length are allowed.
- Back-to-back frames: start_i on the cycle after sample N-1 is accepted normally from IDLE, with no bubble.
- Resync: start_i with valid_i in RUN restarts the frame at index 0 with that sample and pulses sync_err_o in the same cycle. Samples of the aborted frame already in the pipeline still complete. frame_done_o does not fire for the aborted frame.
- Exponent, for an accepted sample with index n:
  - L = FFT_N >> (2·STAGE)
  - m = n mod L
  - q = m / (L/4)
  - p = m mod (L/4)
  - k = {0,2,1,3}[q]
  - e = (p·k) << (2·STAGE)
- Width rule: p·k ≤ 3(L/4-1), so e < FFT_N always. Compute p·k in NLOG2 bits; no truncation or modulo is needed.
- trivial = (q==0) || (p==0).

## Timing

- Cycle 0: valid_i accepted; ctr_o updates at the end of cycle 0.
- Cycle 1: rom_en_o=1 and rom_addr_o=e, registered.
- Cycle 2: ROM data is valid (1-cycle ROM); ce_o, valid_o, trivial_o and frame_done_o are asserted, registered. Total latency from valid_i to ce_o is 2 cycles.
- Data alignment: the caller delays x by 2 cycles to meet w at the multiplier.
- One sample per cycle is sustained; the pipeline never stalls.
- Reset values: state IDLE; all outputs 0.
  - ctr_o = 0
  - rom_addr_o = 0
  - rom_en_o, ce_o, valid_o, trivial_o, frame_done_o, sync_err_o all 0.
- Reset asserted mid-frame: in-flight pipeline valid bits are cleared. Nothing is emitted after reset, and the next frame requires start_i.
- Without valid_i, rom_en_o=0 and rom_addr_o holds its last value.

## Structure

- Shared package fft_pkg holds:
  - the FSM state typedef {IDLE, RUN};
  - the quadrant multiplier constant K_LUT = {0,2,1,3};
  - function clog2.
- Sub-module fft_tw_exp: combinational n → (e, trivial) for a given STAGE. Unit-testable standalone.
- Top level holds the counter, the FSM and the two-stage valid/trivial/done pipeline.

## Test plan

- Single frame, FFT_N=16, STAGE=0, continuous valid:
  - rom_addr_o sequence 0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,9.
  - trivial_o on indices 0-4, 8 and 12.
  - frame_done_o on the 16th ce_o, 2 cycles after the last valid_i.
- FFT_N=64, STAGE=1:
  - indices 4-7 → addresses 0,8,16,24;
  - indices 12-15 → 0,12,24,36;
  - the pattern repeats every 16 samples.
- Gapped valid_i (random 50% duty), FFT_N=16: the address sequence is identical to scenario 1, and each ce_o lands exactly 2 cycles after its valid_i.
- Back-to-back frames with start_i immediately after sample 15: no bubble, and ctr_o wraps 15→0.
- start_i at index 5 of a frame:
  - sync_err_o pulses;
  - the new frame's addresses start at 0;
  - no frame_done_o for the aborted frame.
- Reset asserted at index 7:
  - all outputs are 0 within the same cycle (asynchronous);
  - valid_i without start_i afterwards produces no ce_o.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the R2^2 SDF twiddle scheduler.
// Holds the scheduler FSM states and the quadrant multiplier table.
package fft_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Quadrant multipliers {0,2,1,3}, entry q at bits [2q+1:2q]
    localparam logic [7:0] K_LUT = {2'd3, 2'd1, 2'd2, 2'd0};

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_tw_exp.sv
// Combinational twiddle exponent for one R2^2 SDF stage.
// Maps sample index n to exponent e and a flag for the unit twiddle.
module fft_tw_exp
    import fft_pkg::*;
#(
    parameter int NLOG2 = 10,
    parameter int STAGE = 0
) (
    input  logic [NLOG2-1:0] n,
    output logic [NLOG2-1:0] e,
    output logic             trivial
);

    localparam int LW = NLOG2 - 2 * STAGE;
    localparam int PW = LW - 2;
    localparam logic [NLOG2-1:0] MASK = NLOG2'((1 << LW) - 1);

    logic [NLOG2-1:0] m;
    logic [1:0]       q;
    logic [PW-1:0]    p;
    logic [1:0]       k;
    logic [NLOG2-1:0] prod;

    // Split the in-block position into quadrant and offset, scale by k
    always_comb begin
        m       = n & MASK;
        q       = 2'(m >> PW);
        p       = PW'(m);
        k       = K_LUT[{q, 1'b0} +: 2];
        prod    = NLOG2'(p) * NLOG2'(k);
        e       = prod << (2 * STAGE);
        trivial = (q == 2'd0) || (p == '0);
    end

endmodule

// File: rtl/fft_r22sdf_tw_ctrl.sv
// Twiddle scheduler for one R2^2 SDF stage: frame counter, FSM,
// twiddle ROM addressing and the multiplier enable/valid pipeline.
module fft_r22sdf_tw_ctrl
    import fft_pkg::*;
#(
    parameter int FFT_N = 1024,
    parameter int NLOG2 = 10,
    parameter int STAGE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             start_i,
    output logic [NLOG2-1:0] ctr_o,
    output logic             rom_en_o,
    output logic [NLOG2-1:0] rom_addr_o,
    output logic             ce_o,
    output logic             valid_o,
    output logic             trivial_o,
    output logic             frame_done_o,
    output logic             sync_err_o
);

    localparam logic [NLOG2-1:0] LAST = NLOG2'(FFT_N - 1);

    state_t           state;
    state_t           state_nx;
    logic             acc;
    logic [NLOG2-1:0] idx;
    logic [NLOG2-1:0] e;
    logic             triv;
    logic             s1_triv;
    logic             s1_done;

    fft_tw_exp #(
        .NLOG2(NLOG2),
        .STAGE(STAGE)
    ) u_exp (
        .n      (idx),
        .e      (e),
        .trivial(triv)
    );

    // Decide acceptance, next index and next state for this cycle
    always_comb begin
        state_nx   = state;
        acc        = 1'b0;
        idx        = ctr_o;
        sync_err_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid_i && start_i) begin
                    acc = 1'b1;
                    idx = '0;
                end
            end
            RUN: begin
                if (valid_i) begin
                    acc = 1'b1;
                    if (start_i) begin
                        idx        = '0;
                        sync_err_o = 1'b1;
                    end else begin
                        idx = ctr_o + NLOG2'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (acc) begin
            state_nx = (idx == LAST) ? IDLE : RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Index of the most recently accepted sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctr_o <= '0;
        end else if (acc) begin
            ctr_o <= idx;
        end
    end

    // ROM request stage; address holds between accepted samples
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rom_en_o   <= 1'b0;
            rom_addr_o <= '0;
            s1_triv    <= 1'b0;
            s1_done    <= 1'b0;
        end else begin
            rom_en_o <= acc;
            s1_triv  <= acc && triv;
            s1_done  <= acc && (idx == LAST);
            if (acc) begin
                rom_addr_o <= e;
            end
        end
    end

    // Multiplier stage, aligned with ROM data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_o         <= 1'b0;
            valid_o      <= 1'b0;
            trivial_o    <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            ce_o         <= rom_en_o;
            valid_o      <= rom_en_o;
            trivial_o    <= rom_en_o && s1_triv;
            frame_done_o <= rom_en_o && s1_done;
        end
    end

endmodule

// File: tb/tb_fft_r22sdf_tw_ctrl.sv
// Self-checking bench for fft_r22sdf_tw_ctrl (N=16/S0 and N=64/S1).
// Random stimulus scored against an arithmetic reference model.
module tb_fft_r22sdf_tw_ctrl;

    localparam int SZ = 8192;

    logic clk = 1'b0;
    logic rst;
    logic v16, s16, v64, s64;

    logic [3:0] ctr16, addr16;
    logic       ren16, ce16, vo16, tr16, dn16, se16;
    logic [5:0] ctr64, addr64;
    logic       ren64, ce64, vo64, tr64, dn64, se64;

    fft_r22sdf_tw_ctrl #(.FFT_N(16), .NLOG2(4), .STAGE(0)) dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(v16), .start_i(s16),
        .ctr_o(ctr16), .rom_en_o(ren16), .rom_addr_o(addr16),
        .ce_o(ce16), .valid_o(vo16), .trivial_o(tr16),
        .frame_done_o(dn16), .sync_err_o(se16)
    );

    fft_r22sdf_tw_ctrl #(.FFT_N(64), .NLOG2(6), .STAGE(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(v64), .start_i(s64),
        .ctr_o(ctr64), .rom_en_o(ren64), .rom_addr_o(addr64),
        .ce_o(ce64), .valid_o(vo64), .trivial_o(tr64),
        .frame_done_o(dn64), .sync_err_o(se64)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sel = 0;
    int done_cnt = 0;

    bit e_rom[SZ];
    bit e_ce[SZ];
    bit e_tr[SZ];
    bit e_dn[SZ];
    bit in_frame[2];
    int m_ctr[2];
    int m_addr[2];

    int tbl16[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    int tbl64[16] = '{0, 0, 0, 0, 0, 8, 16, 24, 0, 4, 8, 12, 0, 12, 24, 36};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int cur_n();
        return (sel == 0) ? 16 : 64;
    endfunction

    function automatic int cur_st();
        return (sel == 0) ? 0 : 1;
    endfunction

    // Reference exponent straight from the block/quadrant definition
    function automatic int tw_e(input int n, input int fn, input int st);
        int kt[4] = '{0, 2, 1, 3};
        int l, m, q, p;
        l = fn >> (2 * st);
        m = n % l;
        q = m / (l / 4);
        p = m % (l / 4);
        return (p * kt[q]) << (2 * st);
    endfunction

    function automatic bit tw_triv(input int n, input int fn, input int st);
        int l, m, q, p;
        l = fn >> (2 * st);
        m = n % l;
        q = m / (l / 4);
        p = m % (l / 4);
        return (q == 0) || (p == 0);
    endfunction

    function automatic logic [31:0] cur_addr();
        return (sel == 0) ? 32'(addr16) : 32'(addr64);
    endfunction

    task automatic check_out();
        int i;
        logic [31:0] ro, ra, ce, vo, tr, dn, ct;
        i  = cyc % SZ;
        ro = (sel == 0) ? 32'(ren16) : 32'(ren64);
        ra = cur_addr();
        ce = (sel == 0) ? 32'(ce16) : 32'(ce64);
        vo = (sel == 0) ? 32'(vo16) : 32'(vo64);
        tr = (sel == 0) ? 32'(tr16) : 32'(tr64);
        dn = (sel == 0) ? 32'(dn16) : 32'(dn64);
        ct = (sel == 0) ? 32'(ctr16) : 32'(ctr64);
        chk("rom_en", ro, 32'(e_rom[i]));
        chk("rom_addr", ra, m_addr[sel]);
        chk("ce", ce, 32'(e_ce[i]));
        chk("valid", vo, 32'(e_ce[i]));
        chk("trivial", tr, 32'(e_tr[i]));
        chk("frame_done", dn, 32'(e_dn[i]));
        chk("ctr", ct, m_ctr[sel]);
        if (dn == 32'd1) done_cnt++;
        e_rom[i] = 1'b0;
        e_ce[i]  = 1'b0;
        e_tr[i]  = 1'b0;
        e_dn[i]  = 1'b0;
    endtask

    task automatic tick(input bit v, input bit s);
        int fn, st, idx;
        bit acc, se;
        fn  = cur_n();
        st  = cur_st();
        acc = 1'b0;
        se  = 1'b0;
        idx = 0;
        v16 = (sel == 0) ? v : 1'b0;
        s16 = (sel == 0) ? s : 1'b0;
        v64 = (sel == 1) ? v : 1'b0;
        s64 = (sel == 1) ? s : 1'b0;
        #1;
        if (v && s) begin
            acc = 1'b1;
            se  = in_frame[sel];
        end else if (v && in_frame[sel]) begin
            acc = 1'b1;
            idx = m_ctr[sel] + 1;
        end
        chk("sync_err", (sel == 0) ? 32'(se16) : 32'(se64), 32'(se));
        if (acc) begin
            in_frame[sel] = (idx != fn - 1);
            m_ctr[sel]    = idx;
            m_addr[sel]   = tw_e(idx, fn, st);
            e_rom[(cyc + 1) % SZ] = 1'b1;
            e_ce[(cyc + 2) % SZ]  = 1'b1;
            e_tr[(cyc + 2) % SZ]  = tw_triv(idx, fn, st);
            e_dn[(cyc + 2) % SZ]  = (idx == fn - 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_out();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        logic [31:0] all;
        all = (sel == 0)
            ? 32'({ctr16, addr16, ren16, ce16, vo16, tr16, dn16, se16})
            : 32'({ctr64, addr64, ren64, ce64, vo64, tr64, dn64, se64});
        chk(tag, all, 32'd0);
    endtask

    int k;
    int guard;
    bit v;

    initial begin
        rst = 1'b1;
        v16 = 0; s16 = 0; v64 = 0; s64 = 0;
        for (int j = 0; j < 2; j++) begin
            in_frame[j] = 0; m_ctr[j] = 0; m_addr[j] = 0;
        end
        #12;
        sel = 0; check_zero("reset16");
        sel = 1; check_zero("reset64");
        sel = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out();

        // Single continuous frame, N=16
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, i == 0);
            chk("seq16", cur_addr(), tbl16[i]);
        end
        drain();
        chk("done_cnt_single", done_cnt, 1);

        // Ignored valid without start while idle
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        drain();

        // Gapped frame, N=16
        tick(1'b1, 1'b1);
        k = 1;
        guard = 0;
        while (k < 16 && guard < 400) begin
            v = 1'($urandom_range(0, 1));
            tick(v, 1'b0);
            if (v) begin
                chk("gap_seq", cur_addr(), tbl16[k]);
                k++;
            end
            guard++;
        end
        chk("gap_complete", k, 16);
        drain();

        // Back-to-back frames, no bubble
        done_cnt = 0;
        for (int i = 0; i < 32; i++) tick(1'b1, (i % 16) == 0);
        drain();
        chk("done_cnt_b2b", done_cnt, 2);

        // Resync at index 5
        done_cnt = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, i == 0);
        tick(1'b1, 1'b1);
        chk("resync_addr", cur_addr(), 0);
        for (int i = 1; i < 16; i++) tick(1'b1, 1'b0);
        drain();
        chk("done_cnt_resync", done_cnt, 1);

        // N=64, stage 1: one continuous frame, one gapped frame
        drain();
        sel = 1;
        drain();
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, i == 0);
            chk("seq64", cur_addr(), tbl64[i % 16]);
        end
        tick(1'b1, 1'b1);
        guard = 0;
        while (in_frame[1] && guard < 600) begin
            tick(($urandom_range(0, 3) != 0), 1'b0);
            guard++;
        end
        chk("gap64_complete", 32'(in_frame[1]), 0);
        drain();

        // Reset asserted at index 7
        sel = 0;
        drain();
        for (int i = 0; i < 8; i++) tick(1'b1, i == 0);
        v16 = 1'b0; s16 = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        for (int j = 0; j < 2; j++) begin
            in_frame[j] = 0; m_ctr[j] = 0; m_addr[j] = 0;
        end
        for (int j = 0; j < SZ; j++) begin
            e_rom[j] = 0; e_ce[j] = 0; e_tr[j] = 0; e_dn[j] = 0;
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check_out();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        drain();
        for (int i = 0; i < 16; i++) tick(1'b1, i == 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
